// File: rtl/rsa_pkg.sv
// Shared encodings for the modular-exponentiation sequencer: operand selects, FSM states,
// write destinations and the per-state MM operation table.
package rsa_pkg;

    localparam logic [2:0] SEL_M   = 3'd0;
    localparam logic [2:0] SEL_T   = 3'd1;
    localparam logic [2:0] SEL_Y   = 3'd2;
    localparam logic [2:0] SEL_ONE = 3'd3;
    localparam logic [2:0] SEL_R2  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE_T = 3'd1,
        ST_PRE_Y = 3'd2,
        ST_MUL   = 3'd3,
        ST_SQR   = 3'd4,
        ST_POST  = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_T    = 2'd1,
        DST_Y    = 2'd2
    } dst_e;

    typedef struct packed {
        logic [2:0] a_sel;
        logic [2:0] b_sel;
        dst_e       dst;
    } op_t;

    function automatic op_t op_decode(input state_e st);
        op_t op;
        op = '{a_sel: SEL_ONE, b_sel: SEL_ONE, dst: DST_NONE};
        case (st)
            ST_PRE_T: op = '{a_sel: SEL_M,   b_sel: SEL_R2,  dst: DST_T};
            ST_PRE_Y: op = '{a_sel: SEL_ONE, b_sel: SEL_R2,  dst: DST_Y};
            ST_MUL:   op = '{a_sel: SEL_Y,   b_sel: SEL_T,   dst: DST_Y};
            ST_SQR:   op = '{a_sel: SEL_T,   b_sel: SEL_T,   dst: DST_T};
            ST_POST:  op = '{a_sel: SEL_Y,   b_sel: SEL_ONE, dst: DST_Y};
            default:  op = '{a_sel: SEL_ONE, b_sel: SEL_ONE, dst: DST_NONE};
        endcase
        return op;
    endfunction

    function automatic logic is_op_state(input state_e st);
        return st inside {ST_PRE_T, ST_PRE_Y, ST_MUL, ST_SQR, ST_POST};
    endfunction

endpackage

// File: rtl/rsa_op_issue.sv
// ISSUE/WAIT handshake for one MM operation: go -> mm_start next cycle, then wait for mm_done.
// Latency 1 cycle from go to mm_start; stalls in WAIT for as long as the MM core takes.
module rsa_op_issue (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic cancel,
    input  logic mm_done,
    output logic mm_start,
    output logic op_done,
    output logic busy
);

    logic issue_q, issue_d;
    logic wait_q, wait_d;

    always_comb begin
        issue_d = go & ~cancel;
        wait_d  = ~cancel & (issue_q | (wait_q & ~mm_done));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_q <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            issue_q <= issue_d;
            wait_q  <= wait_d;
        end
    end

    assign mm_start = issue_q;
    assign op_done  = wait_q & mm_done;
    assign busy     = issue_q | wait_q;

endmodule

// File: rtl/rsa_exp_ctrl.sv
// LSB-first square-and-multiply sequencer driving a shared Montgomery multiplier.
// One ISSUE cycle plus MM latency per operation; waits indefinitely on mm_done, abort wins over it.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int EXP_BITS = 256,
    parameter int IDX_W    = $clog2(EXP_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [IDX_W-1:0] exp_idx,
    input  logic             exp_bit,
    output logic             mm_start,
    input  logic             mm_done,
    output logic [2:0]       mm_a_sel,
    output logic [2:0]       mm_b_sel,
    output logic             t_we,
    output logic             y_we,
    output logic             ready,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EXP_BITS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
    logic             ready_q, ready_d;
    logic             go, op_done, busy;
    op_t              op;

    rsa_op_issue u_issue (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .cancel   (abort),
        .mm_done  (mm_done),
        .mm_start (mm_start),
        .op_done  (op_done),
        .busy     (busy)
    );

    assign nxt_idx = idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_PRE_T;
                idx_d   = '0;
            end
            ST_PRE_T: if (op_done) state_d = ST_PRE_Y;
            ST_PRE_Y: if (op_done)
                state_d = exp_bit ? ST_MUL : ((idx_q == LAST_IDX) ? ST_POST : ST_SQR);
            ST_MUL:   if (op_done) state_d = (idx_q == LAST_IDX) ? ST_POST : ST_SQR;
            // exp_bit here is the lookahead bit at idx+1, so the last SQR is skipped on a zero bit
            ST_SQR: if (op_done) begin
                idx_d   = nxt_idx;
                state_d = exp_bit ? ST_MUL : ((nxt_idx == LAST_IDX) ? ST_POST : ST_SQR);
            end
            ST_POST:  if (op_done) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end
        go      = is_op_state(state_d) && ((state_q == ST_IDLE) || op_done);
        ready_d = (state_d == ST_IDLE) || (state_d == ST_FIN);
    end

    always_comb begin
        op       = op_decode(state_q);
        mm_a_sel = busy ? op.a_sel : SEL_ONE;
        mm_b_sel = busy ? op.b_sel : SEL_ONE;
        t_we     = op_done & ~abort & (op.dst == DST_T);
        y_we     = op_done & ~abort & (op.dst == DST_Y);
        exp_idx  = (state_q == ST_SQR && busy && !mm_start) ? nxt_idx : idx_q;
        ready    = ready_q;
        done     = (state_q == ST_FIN);
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl with EXP_BITS=4: 5-cycle Montgomery model, op scoreboard, abort/reset cases.
module tb_rsa_exp_ctrl;
    import rsa_pkg::*;

    localparam int LAT = 5;
    localparam int NM  = 179;
    localparam int MV  = 42;
    localparam int R2I = (1 << 16) % NM;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic       mm_done_m = 1'b0, late_done = 1'b0;
    logic       exp_bit, mm_start, mm_done, t_we, y_we, ready, done;
    logic [1:0] exp_idx;
    logic [2:0] a_sel, b_sel;
    logic [3:0] e_val = 4'd0;

    always #5 clk = ~clk;
    assign mm_done = mm_done_m | late_done;
    assign exp_bit = e_val[exp_idx];

    rsa_exp_ctrl #(.EXP_BITS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .exp_idx(exp_idx), .exp_bit(exp_bit),
        .mm_start(mm_start), .mm_done(mm_done),
        .mm_a_sel(a_sel), .mm_b_sel(b_sel),
        .t_we(t_we), .y_we(y_we), .ready(ready), .done(done)
    );

    int errors = 0, checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int mont(input int a, input int b);
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) s += b;
            if (s[0]) s += NM;
            s = s >> 1;
        end
        if (s >= NM) s -= NM;
        return s;
    endfunction

    function automatic int modexp(input int m, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * m) % NM;
        return r;
    endfunction

    int t_reg = 0, y_reg = 0, mm_res = 0, cnt = 0;

    function automatic int sel_val(input logic [2:0] s);
        case (s)
            SEL_M:   return MV;
            SEL_T:   return t_reg;
            SEL_Y:   return y_reg;
            SEL_ONE: return 1;
            SEL_R2:  return R2I;
            default: return 0;
        endcase
    endfunction

    // Scoreboard entries: {a_sel, b_sel, dst} with dst 0 = T, 1 = Y
    logic [6:0] exp_q[$];

    task automatic push_run(input logic [3:0] e);
        exp_q.push_back({SEL_M, SEL_R2, 1'b0});
        exp_q.push_back({SEL_ONE, SEL_R2, 1'b1});
        for (int i = 0; i < 4; i++) begin
            if (e[i]) exp_q.push_back({SEL_Y, SEL_T, 1'b1});
            if (i < 3) exp_q.push_back({SEL_T, SEL_T, 1'b0});
        end
        exp_q.push_back({SEL_Y, SEL_ONE, 1'b1});
    endtask

    // MM core model: result computed at issue, mm_done LAT cycles later
    initial forever begin
        @(posedge clk);
        #1;
        if (!reset) begin
            cnt = 0;
            mm_done_m = 1'b0;
        end else begin
            mm_done_m = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) mm_done_m = 1'b1;
            end
            if (mm_start) begin
                cnt = LAT;
                mm_res = mont(sel_val(a_sel), sel_val(b_sel));
            end
        end
    end

    logic       in_op = 1'b0;
    logic [6:0] cur = '0;
    int n_starts = 0, n_twe = 0, n_ywe = 0;

    always @(negedge clk) begin
        if (!reset) begin
            in_op = 1'b0;
        end else begin
            if (mm_start) begin
                n_starts++;
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check_eq("a_sel", a_sel, cur[6:4]);
                    check_eq("b_sel", b_sel, cur[3:1]);
                    in_op = 1'b1;
                end
            end
            if (t_we) n_twe++;
            if (y_we) n_ywe++;
            if (mm_done) begin
                if (in_op && !abort) begin
                    check_eq("t_we", t_we, !cur[0]);
                    check_eq("y_we", y_we, cur[0]);
                    if (t_we) t_reg = mm_res;
                    if (y_we) y_reg = mm_res;
                end else begin
                    check_eq("we_ignored", {t_we, y_we}, 0);
                end
                in_op = 1'b0;
            end else if (t_we || y_we) begin
                check_eq("we_stray", {t_we, y_we}, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, ready, 1);
        check_eq({tag, "_mm_start"}, mm_start, 0);
        check_eq({tag, "_t_we"}, t_we, 0);
        check_eq({tag, "_y_we"}, y_we, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_exp_idx"}, exp_idx, 0);
        check_eq({tag, "_a_sel"}, a_sel, SEL_ONE);
        check_eq({tag, "_b_sel"}, b_sel, SEL_ONE);
    endtask

    task automatic launch_and_wait(input logic [3:0] e, input string tag);
        int k, q0, nops, base;
        e_val = e;
        q0 = exp_q.size();
        push_run(e);
        nops = exp_q.size() - q0;
        base = n_starts;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq({tag, "_first_issue"}, {mm_start, ready}, 2'b10);
        k = 1;
        while (!done && k < 2000) begin
            step();
            k++;
        end
        check_eq({tag, "_done_cycle"}, k, nops * (LAT + 1) + 1);
        check_eq({tag, "_op_count"}, n_starts - base, nops);
        check_eq({tag, "_sb_empty"}, exp_q.size(), 0);
        check_eq({tag, "_result"}, y_reg, modexp(MV, int'(e)));
        step();
        check_eq({tag, "_ready_after"}, ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int k, base, tw0, yw0;
        step();
        step();
        check_reset_vals("reset");
        reset = 1'b1;
        step();

        launch_and_wait(4'b1011, "e1011");

        tw0 = n_twe;
        yw0 = n_ywe;
        launch_and_wait(4'b0000, "e0");
        check_eq("e0_y_we_count", n_ywe - yw0, 2);
        check_eq("e0_t_we_count", n_twe - tw0, 4);

        launch_and_wait(4'b1111, "e1111");

        // abort coincident with mm_done of the first MUL
        e_val = 4'b1011;
        push_run(4'b1011);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(mm_done && a_sel == SEL_Y && b_sel == SEL_T) && k < 200) begin
            step();
            k++;
        end
        check_eq("abort_found_mul", 32'(k < 200), 1);
        yw0 = n_ywe;
        abort = 1'b1;
        @(negedge clk);
        #1;
        check_eq("abort_no_y_we", y_we, 0);
        step();
        abort = 1'b0;
        check_eq("abort_ready", ready, 1);
        check_eq("abort_exp_idx", exp_idx, 0);
        check_eq("abort_no_issue", mm_start, 0);
        exp_q.delete();
        step();
        late_done = 1'b1;
        #1;
        check_eq("late_done_strobes", {t_we, y_we}, 0);
        step();
        late_done = 1'b0;
        check_eq("abort_y_we_count", n_ywe - yw0, 0);
        step();

        // start held high: back-to-back runs with one IDLE cycle, busy pulses ignored
        e_val = 4'b0000;
        push_run(4'b0000);
        push_run(4'b0000);
        base = n_starts;
        start = 1'b1;
        step();
        k = 1;
        while (!done && k < 2000) begin
            step();
            k++;
        end
        check_eq("held_run1_cycle", k, 6 * (LAT + 1) + 1);
        check_eq("held_run1_ops", n_starts - base, 6);
        step();
        check_eq("held_idle_gap", {ready, mm_start}, 2'b10);
        step();
        check_eq("held_restart", {ready, mm_start}, 2'b01);
        base = n_starts;
        for (int i = 0; i < 12; i++) begin
            start = i[0];
            step();
        end
        start = 1'b0;
        k = 0;
        while (!done && k < 2000) begin
            step();
            k++;
        end
        check_eq("held_run2_done_seen", done, 1);
        check_eq("held_run2_ops", n_starts - base, 6);
        check_eq("held_sb_empty", exp_q.size(), 0);
        check_eq("held_result", y_reg, 1);
        step();

        // asynchronous reset during SQR WAIT, then a full fresh run
        e_val = 4'b1011;
        push_run(4'b1011);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(a_sel == SEL_T && b_sel == SEL_T && !mm_start) && k < 200) begin
            step();
            k++;
        end
        check_eq("rst_found_sqr_wait", 32'(k < 200), 1);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("rst_async");
        step();
        check_reset_vals("rst_held");
        exp_q.delete();
        reset = 1'b1;
        step();
        launch_and_wait(4'b1011, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Control-only sequencer for modular exponentiation Y = M^E mod N on a shared Montgomery multiplier (MM) datapath. It walks the exponent LSB-first with square-and-multiply and issues one MM operation at a time. For each operation it selects the operands and the destination register, and raises the register write strobes. It sits between the byte-wide host register file (M, E, N, result) and the MM core, and it drives the host-visible `ready` flag.

## Interface
Parameters:
- `EXP_BITS`, default 256: exponent width and number of loop iterations.
- `IDX_W`, default $clog2(EXP_BITS): width of the exponent bit index.

Ports (clock and reset first):
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to begin. Accepted only in IDLE.
- `abort`  in  1  synchronous cancel. Returns to IDLE next cycle from any state.
- `exp_idx`  out  IDX_W  index of the exponent bit currently examined.
- `exp_bit`  in  1  E[exp_idx], returned combinationally by the register file.
- `mm_start`  out  1  one-cycle pulse that launches an MM operation.
- `mm_done`  in  1  one-cycle pulse from the MM core; the result is valid in that cycle.
- `mm_a_sel`  out  3  operand A select: SEL_M, SEL_T, SEL_Y, SEL_ONE, SEL_R2.
- `mm_b_sel`  out  3  operand B select, same encoding.
- `t_we`  out  1  write MM result into T.
- `y_we`  out  1  write MM result into Y.
- `ready`  out  1  high while idle or finished; low while busy.
- `done`  out  1  one-cycle pulse when Y holds the final result.

## Operation
- States: IDLE, PRE_T, PRE_Y, MUL, SQR, POST, FIN.
- Every state except IDLE and FIN has two phases:
  - ISSUE: one cycle; `mm_start`=1, selects driven.
  - WAIT: selects held stable; waits for `mm_done`.
- Operations per state:
  - PRE_T: T ← MM(M, R2), i.e. M into the Montgomery domain.
  - PRE_Y: Y ← MM(ONE, R2), i.e. R mod N.
  - MUL: Y ← MM(Y, T).
  - SQR: T ← MM(T, T).
  - POST: Y ← MM(Y, ONE), i.e. out of the Montgomery domain.
- `t_we`/`y_we` equal `mm_done` gated by the destination of the current state. No other cycle asserts them.
- Transitions:
  - IDLE→PRE_T on `start`; `exp_idx` cleared to 0.
  - PRE_T→PRE_Y on done.
  - PRE_Y on done: →MUL if `exp_bit`, else →SQR.
  - MUL on done: →SQR if `exp_idx`≠EXP_BITS-1, else →POST.
  - SQR on done: `exp_idx`++, then →MUL if the next bit is 1, else →SQR.
  - The final iteration skips SQR. When `exp_bit`=0 at `exp_idx`=EXP_BITS-1, go directly to POST.
  - POST→FIN on done. FIN→IDLE after one cycle; `done`=1 in FIN.
- `exp_bit` is sampled in the cycle the decision is made. The next-bit lookahead uses `exp_idx`+1 driven combinationally while in SQR WAIT.
- `start` in any non-IDLE state is ignored. `start` held high across FIN→IDLE re-triggers on the next cycle.
- `abort` takes precedence over `mm_done` in the same cycle: no write strobe, state→IDLE, `exp_idx`→0. An MM result that arrives afterwards is ignored, because IDLE never asserts write strobes.
- `mm_done` during ISSUE is illegal; the design need not handle it.

## Timing
- Reset values: state=IDLE, `exp_idx`=0, `mm_start`=0, `t_we`=`y_we`=0, `done`=0, `ready`=1, both selects=SEL_ONE.
- `start` high at edge n → PRE_T ISSUE in cycle n+1, so `mm_start` and `ready`=0 are seen in cycle n+1.
- `mm_done` at edge k → the write strobe is asserted in cycle k (same cycle, combinational) → next ISSUE in cycle k+1.
- Control overhead per MM operation: 1 ISSUE cycle plus the MM latency.
- FIN is one cycle, then `ready`=1. `ready` is a registered decode of state; it is low from ISSUE of PRE_T through POST WAIT.
- Reset assertion mid-run: immediate return to the reset values; no strobes while reset is held.

## Structure
- `rsa_pkg` holds:
  - the 3-bit operand-select constants SEL_M=0, SEL_T=1, SEL_Y=2, SEL_ONE=3, SEL_R2=4;
  - the state encoding;
  - the destination encoding (DST_T, DST_Y).
- Sub-module `rsa_op_issue` implements the generic ISSUE/WAIT handshake: a `go` input, `mm_start` and `mm_done` passthrough, and a `busy` output. The FSM instantiates it once.

## Test plan
- EXP_BITS=4, E=4'b1011, MM model with 5-cycle latency → exactly 9 `mm_start` pulses.
  - Select/destination sequence: (M,R2→T), (ONE,R2→Y), MUL, SQR, MUL, SQR, SQR, MUL, POST.
  - `done` arrives 9×6+1 cycles after `start` is accepted.
- E=0 → 6 operations: PRE_T, PRE_Y, SQR, SQR, SQR, POST; `y_we` fires only in PRE_Y and POST.
- E=4'b1111 with an MM result model → final Y equals M^15 mod N for N=0xB3, M=0x2A, checked against a software reference.
- `abort` asserted in the same cycle as `mm_done` during MUL → no `y_we`, `ready`=1 next cycle, `exp_idx`=0. A late `mm_done` produces no strobe.
- `start` held high continuously → after `done`, a new run begins with 1 IDLE cycle between runs. `start` pulses while busy do not change the operation count.
- `reset` deasserted-low (asserted) during SQR WAIT → all outputs at reset values asynchronously; a fresh `start` runs the full sequence.
